// File: rtl/template_list_parser_if.sv
// Handshake bundle between the template-list byte source, the parser and the
// downstream word generator.
interface template_list_parser_if #(
  parameter int CHAR_BITS      = 7,
  parameter int RANGES_MAX     = 4,
  parameter int WORD_MAX_LEN   = 8,
  parameter int RANGE_INFO_MSB = 3
);
  logic [7:0]                                   din;
  logic                                         wr_en;
  logic                                         pkt_end;
  logic                                         full;
  logic [WORD_MAX_LEN*CHAR_BITS-1:0]            word_out;
  logic [RANGES_MAX*(RANGE_INFO_MSB+1)-1:0]     range_info;
  logic [15:0]                                  word_id;
  logic                                         word_list_end;
  logic                                         word_wr_en;
  logic                                         word_full;
  logic                                         err_template;

  // Parser side: consumes bytes, produces words.
  modport slave (
    input  din, wr_en, pkt_end, word_full,
    output full, word_out, range_info, word_id, word_list_end, word_wr_en, err_template
  );

  // Environment side: byte source plus word generator.
  modport master (
    output din, wr_en, pkt_end, word_full,
    input  full, word_out, range_info, word_id, word_list_end, word_wr_en, err_template
  );
endinterface

// File: rtl/template_list_parser.sv
// Template-list payload parser: assembles chars and range bytes into one word per
// template, hands it to the word generator, and closes each packet with a dummy word.
module template_list_parser #(
  parameter int CHAR_BITS      = 7,
  parameter int RANGES_MAX     = 4,
  parameter int WORD_MAX_LEN   = 8,
  parameter int RANGE_INFO_MSB = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  template_list_parser_if.slave bus
);

  localparam int WORD_W  = WORD_MAX_LEN * CHAR_BITS;
  localparam int RANGE_W = RANGE_INFO_MSB + 1;
  localparam int INFO_W  = RANGES_MAX * RANGE_W;
  localparam int CC_W    = (WORD_MAX_LEN > 1) ? $clog2(WORD_MAX_LEN) : 1;
  localparam int RC_W    = (RANGES_MAX > 1) ? $clog2(RANGES_MAX) : 1;

  typedef enum logic [2:0] {
    S_CHARS,
    S_RANGES,
    S_OUT,
    S_END,
    S_ERROR
  } state_t;

  state_t              state, state_next;
  logic [WORD_W-1:0]   word_r;
  logic [INFO_W-1:0]   range_r;
  logic [CC_W-1:0]     char_cnt;
  logic [RC_W-1:0]     range_cnt;
  logic                last_r;
  logic [15:0]         word_id_r;

  logic                accept;
  logic                transfer;
  logic                char_last;
  logic                char_term;
  logic                char_bad;
  logic                range_last;
  logic                range_bad;
  logic [31:0]         range_pos;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_next = state;
    accept     = bus.wr_en & ~bus.full;
    transfer   = bus.word_wr_en & ~bus.word_full;
    char_last  = (char_cnt == CC_W'(WORD_MAX_LEN - 1));
    char_term  = (bus.din == 8'd0);
    char_bad   = bus.pkt_end | ((CHAR_BITS == 7) & bus.din[7]);
    range_last = (range_cnt == RC_W'(RANGES_MAX - 1));
    range_pos  = 32'(bus.din[RANGE_INFO_MSB-1:0]);
    // pkt_end is only legal on the final range byte of a template.
    range_bad  = ((bus.din >> RANGE_W) != 8'd0)
               | (bus.din[RANGE_INFO_MSB] & (range_pos >= 32'(WORD_MAX_LEN)))
               | (bus.pkt_end & ~range_last);

    case (state)
      S_CHARS: begin
        if (accept) begin
          if (char_bad)                   state_next = S_ERROR;
          else if (char_term | char_last) state_next = S_RANGES;
        end
      end
      S_RANGES: begin
        if (accept) begin
          if (range_bad)       state_next = S_ERROR;
          else if (range_last) state_next = S_OUT;
        end
      end
      S_OUT:   if (!bus.word_full) state_next = last_r ? S_END : S_CHARS;
      S_END:   if (!bus.word_full) state_next = S_CHARS;
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_ERROR;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (RST) state <= S_CHARS;
    else     state <= state_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_r    <= '0;
      range_r   <= '0;
      char_cnt  <= '0;
      range_cnt <= '0;
      last_r    <= 1'b0;
      word_id_r <= '0;
    end else begin
      case (state)
        S_CHARS: begin
          if (accept && !char_bad) begin
            if (!char_term) word_r[char_cnt*CHAR_BITS +: CHAR_BITS] <= bus.din[CHAR_BITS-1:0];
            if (char_term || char_last) range_cnt <= '0;
            else                        char_cnt  <= char_cnt + 1'b1;
          end
        end
        S_RANGES: begin
          if (accept && !range_bad) begin
            range_r[range_cnt*RANGE_W +: RANGE_W] <= bus.din[RANGE_W-1:0];
            if (range_last) last_r    <= bus.pkt_end;
            else            range_cnt <= range_cnt + 1'b1;
          end
        end
        S_OUT: begin
          // Word handed over: start the next template from a blank word.
          if (transfer) begin
            word_id_r <= word_id_r + 16'd1;
            word_r    <= '0;
            char_cnt  <= '0;
            range_cnt <= '0;
          end
        end
        S_END: begin
          if (transfer) word_id_r <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.full          = !(state == S_CHARS || state == S_RANGES);
  assign bus.word_wr_en    = (state == S_OUT) || (state == S_END);
  assign bus.word_list_end = (state == S_END);
  assign bus.err_template  = (state == S_ERROR);
  assign bus.word_out      = (state == S_END) ? '0 : word_r;
  assign bus.range_info    = (state == S_END) ? '0 : range_r;
  assign bus.word_id       = word_id_r;

endmodule

// File: tb/tb_template_list_parser.sv
// Directed and randomized bench for template_list_parser; expected words are
// computed from template contents, not from the parser's internal state.
module tb_template_list_parser;

  localparam int CB  = 7;
  localparam int RM  = 4;
  localparam int WML = 8;
  localparam int RIM = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  template_list_parser_if #(.CHAR_BITS(CB), .RANGES_MAX(RM), .WORD_MAX_LEN(WML),
                            .RANGE_INFO_MSB(RIM)) bus ();

  template_list_parser #(.CHAR_BITS(CB), .RANGES_MAX(RM), .WORD_MAX_LEN(WML),
                         .RANGE_INFO_MSB(RIM)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Reference template: characters, range bytes, and the byte stream they form.
  logic [7:0]  cur_chars[WML];
  logic [7:0]  cur_rng[RM];
  int          cur_n;
  logic [7:0]  tq[$];
  logic [55:0] exp_w;
  logic [15:0] exp_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build();
    tq.delete();
    exp_w = '0;
    exp_r = '0;
    for (int k = 0; k < cur_n; k++) begin
      tq.push_back(cur_chars[k]);
      exp_w = exp_w | (56'(cur_chars[k][6:0]) << (CB * k));
    end
    if (cur_n < WML) tq.push_back(8'h00);
    for (int j = 0; j < RM; j++) begin
      tq.push_back(cur_rng[j]);
      exp_r = exp_r | (16'(cur_rng[j][3:0]) << ((RIM + 1) * j));
    end
  endtask

  task automatic randomize_template();
    cur_n = $urandom_range(0, WML);
    for (int k = 0; k < WML; k++) cur_chars[k] = 8'($urandom_range(1, 127));
    for (int j = 0; j < RM; j++)
      cur_rng[j] = ($urandom_range(0, 1) == 1) ? (8'h08 | 8'($urandom_range(0, 7))) : 8'h00;
    build();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    while (bus.full === 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check("send_wait_full", 64'(bus.full), 64'd0);
    bus.din     = b;
    bus.wr_en   = 1'b1;
    bus.pkt_end = last;
    @(negedge CLK);
    bus.wr_en   = 1'b0;
    bus.pkt_end = 1'b0;
    bus.din     = 8'h00;
  endtask

  task automatic send_template(input logic last);
    for (int i = 0; i < tq.size(); i++) send_byte(tq[i], last && (i == tq.size() - 1));
  endtask

  task automatic take_word(input string tag, input logic [15:0] id, input int stall);
    check({tag, "_wr_en"}, 64'(bus.word_wr_en), 64'd1);
    check({tag, "_full"},  64'(bus.full), 64'd1);
    check({tag, "_end"},   64'(bus.word_list_end), 64'd0);
    check({tag, "_word"},  64'(bus.word_out), 64'(exp_w));
    check({tag, "_range"}, 64'(bus.range_info), 64'(exp_r));
    check({tag, "_id"},    64'(bus.word_id), 64'(id));
    bus.word_full = (stall > 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      check({tag, "_stall_wr_en"}, 64'(bus.word_wr_en), 64'd1);
      check({tag, "_stall_word"},  64'(bus.word_out), 64'(exp_w));
    end
    bus.word_full = 1'b0;
    @(negedge CLK);
  endtask

  task automatic take_dummy(input string tag, input logic [15:0] id);
    check({tag, "_wr_en"}, 64'(bus.word_wr_en), 64'd1);
    check({tag, "_end"},   64'(bus.word_list_end), 64'd1);
    check({tag, "_word"},  64'(bus.word_out), 64'd0);
    check({tag, "_range"}, 64'(bus.range_info), 64'd0);
    check({tag, "_id"},    64'(bus.word_id), 64'(id));
    @(negedge CLK);
    check({tag, "_after_wr_en"}, 64'(bus.word_wr_en), 64'd0);
    check({tag, "_after_id"},    64'(bus.word_id), 64'd0);
    check({tag, "_after_full"},  64'(bus.full), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_full"},  64'(bus.full), 64'd0);
    check({tag, "_wr_en"}, 64'(bus.word_wr_en), 64'd0);
    check({tag, "_end"},   64'(bus.word_list_end), 64'd0);
    check({tag, "_word"},  64'(bus.word_out), 64'd0);
    check({tag, "_range"}, 64'(bus.range_info), 64'd0);
    check({tag, "_id"},    64'(bus.word_id), 64'd0);
    check({tag, "_err"},   64'(bus.err_template), 64'd0);
  endtask

  task automatic pulse_reset(input string tag);
    RST = 1'b1;
    #1;
    check_all_zero(tag);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic check_error(input string tag);
    check({tag, "_err"},   64'(bus.err_template), 64'd1);
    check({tag, "_full"},  64'(bus.full), 64'd1);
    check({tag, "_wr_en"}, 64'(bus.word_wr_en), 64'd0);
  endtask

  initial begin
    int c0;
    int nt;
    logic [55:0] hold_w;
    bus.din = 8'h00; bus.wr_en = 1'b0; bus.pkt_end = 1'b0; bus.word_full = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    @(negedge CLK);

    // "ab" packet: word after 7 cycles, dummy with id 1, then id back to 0
    cur_n = 2; cur_chars[0] = 8'h61; cur_chars[1] = 8'h62;
    for (int j = 0; j < RM; j++) cur_rng[j] = 8'h00;
    build();
    c0 = cyc;
    send_template(1'b1);
    check("ab_latency", 64'(cyc - c0), 64'd7);
    take_word("ab", 16'd0, 0);
    take_dummy("ab_dummy", 16'd1);

    // Full-length word without terminator, range0 active at position 2
    cur_n = 8;
    for (int k = 0; k < WML; k++) cur_chars[k] = 8'h41 + 8'(k);
    cur_rng[0] = 8'h0A; cur_rng[1] = 8'h00; cur_rng[2] = 8'h00; cur_rng[3] = 8'h00;
    build();
    check("full8_bytes", 64'(tq.size()), 64'd12);
    send_template(1'b0);
    take_word("full8", 16'd0, 0);
    check("full8_back_full", 64'(bus.full), 64'd0);

    // word_full held for 20 cycles while junk bytes are offered
    cur_n = 3; cur_chars[0] = 8'h78; cur_chars[1] = 8'h79; cur_chars[2] = 8'h7A;
    cur_rng[0] = 8'h00; cur_rng[1] = 8'h09; cur_rng[2] = 8'h00; cur_rng[3] = 8'h0F;
    build();
    send_template(1'b1);
    hold_w = exp_w;
    bus.word_full = 1'b1;
    for (int s = 0; s < 20; s++) begin
      bus.wr_en = 1'b1;
      bus.din   = 8'($urandom_range(1, 127));
      @(negedge CLK);
      check("hold_wr_en", 64'(bus.word_wr_en), 64'd1);
      check("hold_full",  64'(bus.full), 64'd1);
      check("hold_word",  64'(bus.word_out), 64'(hold_w));
      check("hold_range", 64'(bus.range_info), 64'(exp_r));
      check("hold_id",    64'(bus.word_id), 64'd1);
    end
    bus.wr_en = 1'b0;
    bus.din   = 8'h00;
    bus.word_full = 1'b0;
    @(negedge CLK);
    take_dummy("hold_dummy", 16'd2);

    // pkt_end on a char byte after partial word
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    check_error("pktend_char");
    for (int s = 0; s < 3; s++) begin
      bus.wr_en = 1'b1;
      bus.din   = 8'h41;
      @(negedge CLK);
      check_error("pktend_stuck");
    end
    bus.wr_en = 1'b0;
    pulse_reset("pktend_reset");

    // Char with bit 7 set
    send_byte(8'h80, 1'b0);
    check_error("char_80");
    pulse_reset("char_80_reset");

    // Range byte with a bit above the range field
    send_byte(8'h61, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    check_error("range_20");
    pulse_reset("range_20_reset");

    // pkt_end on a range byte that is not the last one
    send_byte(8'h61, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    check_error("pktend_range");
    pulse_reset("pktend_range_reset");

    // Three-template packet interrupted by reset inside the second template
    randomize_template();
    send_template(1'b0);
    take_word("mid_t0", 16'd0, 0);
    cur_n = 4;
    build();
    send_byte(tq[0], 1'b0);
    send_byte(tq[1], 1'b0);
    pulse_reset("mid_reset");
    cur_n = 0;
    for (int j = 0; j < RM; j++) cur_rng[j] = 8'h00;
    cur_rng[2] = 8'h0F;
    build();
    send_template(1'b1);
    take_word("restart_empty", 16'd0, 0);
    take_dummy("restart_dummy", 16'd1);

    // Randomized packets with random back-pressure
    for (int p = 0; p < 8; p++) begin
      nt = $urandom_range(1, 4);
      for (int t = 0; t < nt; t++) begin
        randomize_template();
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        send_template(t == nt - 1);
        take_word("rand", 16'(t), $urandom_range(0, 3));
      end
      take_dummy("rand_dummy", 16'(nt));
    end
    check("final_err", 64'(bus.err_template), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
